// File: rtl/ddr4_cmd_issuer.sv
// DDR4 closed-page command issuer: pops one request, issues ACT -> RD|WR -> PRE with timing.
// Optional `DDR4_CMD_TRACE_EN` prints one line per issued command (simulation only).
module ddr4_cmd_issuer #(
  parameter int unsigned TRcd = 24,
  parameter int unsigned TRas = 52,
  parameter int unsigned TRp  = 24,
  parameter int unsigned TCl  = 24,
  parameter int unsigned TCwl = 20,
  parameter int unsigned TBl  = 4,
  parameter int unsigned TWr  = 20
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [63:0] now_time_i,
  input  logic        req_valid_i,
  input  logic [63:0] req_time_i,
  input  logic [1:0]  req_op_i,
  input  logic [35:0] req_addr_i,
  output logic        req_ready_o,
  output logic        cmd_valid_o,
  output logic [2:0]  cmd_code_o,
  output logic [1:0]  cmd_bg_o,
  output logic [1:0]  cmd_bank_o,
  output logic [17:0] cmd_row_o,
  output logic [7:0]  cmd_col_o,
  output logic        busy_o
);

  localparam logic [2:0] CmdNop = 3'd0;
  localparam logic [2:0] CmdAct = 3'd1;
  localparam logic [2:0] CmdRd  = 3'd2;
  localparam logic [2:0] CmdWr  = 3'd3;
  localparam logic [2:0] CmdPre = 3'd4;

  // PRE delay measured from the RD/WR cycle; tRAS is re-expressed relative to that cycle.
  localparam int unsigned RasRem     = (TRas > TRcd) ? (TRas - TRcd) : 0;
  localparam int unsigned RdBurstEnd = TCl + TBl;
  localparam int unsigned WrBurstEnd = TCwl + TBl + TWr;
  localparam int unsigned RdPreInt   = (RasRem > RdBurstEnd) ? RasRem : RdBurstEnd;
  localparam int unsigned WrPreInt   = (RasRem > WrBurstEnd) ? RasRem : WrBurstEnd;

  localparam logic [7:0] RdPreDly = 8'(RdPreInt);
  localparam logic [7:0] WrPreDly = 8'(WrPreInt);
  localparam logic [7:0] RcdLoad  = 8'((TRcd > 1) ? (TRcd - 1) : 0);
  // IDLE is re-entered one cycle early so the next ACT can land exactly tRP after PRE.
  localparam logic [7:0] RpLoad   = 8'((TRp > 2) ? (TRp - 2) : 0);

  typedef enum logic [2:0] {
    StIdle,
    StAct,
    StWaitRcd,
    StRw,
    StWaitPre,
    StPre,
    StWaitRp
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  bg_q, bg_d;
  logic [1:0]  bank_q, bank_d;
  logic [17:0] row_q, row_d;
  logic [7:0]  col_q, col_d;

  logic        accept;
  logic [7:0]  pre_dly;

  assign accept  = req_ready_o;
  assign pre_dly = wr_q ? WrPreDly : RdPreDly;

  // State and counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latched request; fields are only sampled on the handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q   <= 1'b0;
      bg_q   <= 2'd0;
      bank_q <= 2'd0;
      row_q  <= 18'd0;
      col_q  <= 8'd0;
    end else begin
      wr_q   <= wr_d;
      bg_q   <= bg_d;
      bank_q <= bank_d;
      row_q  <= row_d;
      col_q  <= col_d;
    end
  end

  always_comb begin
    wr_d   = wr_q;
    bg_d   = bg_q;
    bank_d = bank_q;
    row_d  = row_q;
    col_d  = col_q;
    if (accept) begin
      wr_d   = (req_op_i == 2'd1);
      bg_d   = req_addr_i[7:6];
      bank_d = req_addr_i[9:8];
      col_d  = req_addr_i[17:10];
      row_d  = req_addr_i[35:18];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StAct;
        end
      end
      StAct: begin
        if (RcdLoad == 8'd0) begin
          state_d = StRw;
        end else begin
          state_d = StWaitRcd;
          cnt_d   = RcdLoad;
        end
      end
      StWaitRcd: begin
        if (cnt_q <= 8'd1) begin
          state_d = StRw;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StRw: begin
        if (pre_dly <= 8'd1) begin
          state_d = StPre;
        end else begin
          state_d = StWaitPre;
          cnt_d   = pre_dly - 8'd1;
        end
      end
      StWaitPre: begin
        if (cnt_q <= 8'd1) begin
          state_d = StPre;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StPre: begin
        if (RpLoad == 8'd0) begin
          state_d = StIdle;
        end else begin
          state_d = StWaitRp;
          cnt_d   = RpLoad;
        end
      end
      StWaitRp: begin
        if (cnt_q <= 8'd1) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs; req_ready is gated by reset so nothing is popped while reset is held.
  always_comb begin
    req_ready_o = 1'b0;
    cmd_valid_o = 1'b0;
    cmd_code_o  = CmdNop;
    busy_o      = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        req_ready_o = rst_ni && req_valid_i && (now_time_i >= req_time_i);
      end
      StAct: begin
        cmd_valid_o = 1'b1;
        cmd_code_o  = CmdAct;
      end
      StRw: begin
        cmd_valid_o = 1'b1;
        cmd_code_o  = wr_q ? CmdWr : CmdRd;
      end
      StPre: begin
        cmd_valid_o = 1'b1;
        cmd_code_o  = CmdPre;
      end
      default: begin
        cmd_valid_o = 1'b0;
      end
    endcase
  end

  assign cmd_bg_o   = bg_q;
  assign cmd_bank_o = bank_q;
  assign cmd_row_o  = row_q;
  assign cmd_col_o  = col_q;

`ifdef DDR4_CMD_TRACE_EN
  always_ff @(posedge clk_i) begin
    if (cmd_valid_o) begin
      unique case (cmd_code_o)
        CmdAct:  $display("%0d ACT bg=%h bank=%h row|col=%h", now_time_i, bg_q, bank_q, row_q);
        CmdRd:   $display("%0d RD bg=%h bank=%h row|col=%h", now_time_i, bg_q, bank_q, col_q);
        CmdWr:   $display("%0d WR bg=%h bank=%h row|col=%h", now_time_i, bg_q, bank_q, col_q);
        default: $display("%0d PRE bg=%h bank=%h row|col=%h", now_time_i, bg_q, bank_q, row_q);
      endcase
    end
  end
`endif

endmodule
